// File: rtl/alu_result_stage.sv
// ALU result stage: registers each ALU result and routes it to register write-back or a store handshake.
// Optional same-cycle forwarding outputs are built when ALU_RESULT_FORWARD_EN is defined.

package definitions;
  localparam int DATA_WIDTH = 8;
  localparam int FUNC_WIDTH = 4;

  localparam int FUNC_ADD = 0;
  localparam int FUNC_SUB = 1;
  localparam int FUNC_AND = 2;
  localparam int FUNC_OR  = 3;
  localparam int FUNC_NOT = 4;
  localparam int FUNC_LSS = 5;
  localparam int FUNC_EQL = 6;
  localparam int FUNC_GRT = 7;
  localparam int FUNC_SV  = 8;
endpackage

module alu_result_stage #(
  parameter int DATA_WIDTH     = definitions::DATA_WIDTH,
  parameter int FUNC_WIDTH     = definitions::FUNC_WIDTH,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                      _clk,
  input  logic                      _reset,
  input  logic                      _valid,
  output logic                      ready,
  input  logic [DATA_WIDTH-1:0]     _result,
  input  logic                      _overflow,
  input  logic                      _compareBit,
  input  logic [FUNC_WIDTH-1:0]     _funcCode,
  input  logic [REG_ADDR_WIDTH-1:0] _destReg,
  input  logic [MEM_ADDR_WIDTH-1:0] _storeAddr,
  input  logic                      _flush,
  input  logic                      _clearOverflow,
  output logic                      wbWriteEn,
  output logic [REG_ADDR_WIDTH-1:0] wbReg,
  output logic [DATA_WIDTH-1:0]     wbData,
  output logic                      memReq,
  output logic [MEM_ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0]     memData,
  input  logic                      _memAck,
`ifdef ALU_RESULT_FORWARD_EN
  output logic                      fwdValid,
  output logic [REG_ADDR_WIDTH-1:0] fwdReg,
  output logic [DATA_WIDTH-1:0]     fwdData,
`endif
  output logic                      compareFlag,
  output logic                      overflowFlag
);

  typedef enum logic {IDLE, STORE} state_t;

  state_t                    state_q, state_d;
  logic                      wbWriteEn_q, wbWriteEn_d;
  logic [REG_ADDR_WIDTH-1:0] wbReg_q, wbReg_d;
  logic [DATA_WIDTH-1:0]     wbData_q, wbData_d;
  logic                      memReq_q, memReq_d;
  logic [MEM_ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0]     memData_q, memData_d;
  logic                      compareFlag_q, compareFlag_d;
  logic                      overflowFlag_q, overflowFlag_d;

  logic accept;
  logic is_sv;
  logic is_cmp;

  assign ready  = (state_q == IDLE);
  assign accept = _valid & ready & ~_flush;
  assign is_sv  = (_funcCode == FUNC_WIDTH'(definitions::FUNC_SV));
  assign is_cmp = (_funcCode == FUNC_WIDTH'(definitions::FUNC_NOT)) ||
                  (_funcCode == FUNC_WIDTH'(definitions::FUNC_LSS)) ||
                  (_funcCode == FUNC_WIDTH'(definitions::FUNC_EQL)) ||
                  (_funcCode == FUNC_WIDTH'(definitions::FUNC_GRT));

  always_comb begin
    state_d        = state_q;
    wbWriteEn_d    = 1'b0;
    wbReg_d        = wbReg_q;
    wbData_d       = wbData_q;
    memReq_d       = memReq_q;
    memAddr_d      = memAddr_q;
    memData_d      = memData_q;
    compareFlag_d  = compareFlag_q;
    overflowFlag_d = overflowFlag_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_sv) begin
            state_d   = STORE;
            memReq_d  = 1'b1;
            memAddr_d = _storeAddr;
            memData_d = _result;
          end else begin
            wbWriteEn_d = 1'b1;
            wbReg_d     = _destReg;
            wbData_d    = _result;
          end
        end
      end
      STORE: begin
        // Store payload stays frozen until memory takes it.
        if (_memAck) begin
          state_d  = IDLE;
          memReq_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && is_cmp) compareFlag_d = _compareBit;

    // A new overflow beats a simultaneous clear so no event is lost.
    if (accept && _overflow)  overflowFlag_d = 1'b1;
    else if (_clearOverflow)  overflowFlag_d = 1'b0;
  end

  always_ff @(posedge _clk) begin
    if (_reset) begin
      state_q        <= IDLE;
      wbWriteEn_q    <= 1'b0;
      wbReg_q        <= '0;
      wbData_q       <= '0;
      memReq_q       <= 1'b0;
      memAddr_q      <= '0;
      memData_q      <= '0;
      compareFlag_q  <= 1'b0;
      overflowFlag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wbWriteEn_q    <= wbWriteEn_d;
      wbReg_q        <= wbReg_d;
      wbData_q       <= wbData_d;
      memReq_q       <= memReq_d;
      memAddr_q      <= memAddr_d;
      memData_q      <= memData_d;
      compareFlag_q  <= compareFlag_d;
      overflowFlag_q <= overflowFlag_d;
    end
  end

  assign wbWriteEn    = wbWriteEn_q;
  assign wbReg        = wbReg_q;
  assign wbData       = wbData_q;
  assign memReq       = memReq_q;
  assign memAddr      = memAddr_q;
  assign memData      = memData_q;
  assign compareFlag  = compareFlag_q;
  assign overflowFlag = overflowFlag_q;

`ifdef ALU_RESULT_FORWARD_EN
  assign fwdValid = accept & ~is_sv;
  assign fwdReg   = _destReg;
  assign fwdData  = _result;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios followed by randomized traffic against a behavioural model.

module tb_alu_result_stage;

  localparam int DW = 8;
  localparam int FW = 4;
  localparam int RW = 3;
  localparam int AW = 8;

  localparam logic [FW-1:0] F_ADD = 4'd0;
  localparam logic [FW-1:0] F_NOT = 4'd4;
  localparam logic [FW-1:0] F_LSS = 4'd5;
  localparam logic [FW-1:0] F_EQL = 4'd6;
  localparam logic [FW-1:0] F_GRT = 4'd7;
  localparam logic [FW-1:0] F_SV  = 4'd8;

  logic          clk = 1'b0;
  logic          rst, valid, ovf, cmpb, flush, clr, ack;
  logic [DW-1:0] result;
  logic [FW-1:0] func;
  logic [RW-1:0] dreg;
  logic [AW-1:0] saddr;
  logic          ready, wb_en, mem_req, cmp_flag, ovf_flag;
  logic [RW-1:0] wb_reg;
  logic [DW-1:0] wb_data, mem_data;
  logic [AW-1:0] mem_addr;
`ifdef ALU_RESULT_FORWARD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_reg;
  logic [DW-1:0] fwd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .DATA_WIDTH(DW), .FUNC_WIDTH(FW), .REG_ADDR_WIDTH(RW), .MEM_ADDR_WIDTH(AW)
  ) dut (
    ._clk(clk), ._reset(rst), ._valid(valid), .ready(ready),
    ._result(result), ._overflow(ovf), ._compareBit(cmpb), ._funcCode(func),
    ._destReg(dreg), ._storeAddr(saddr), ._flush(flush), ._clearOverflow(clr),
    .wbWriteEn(wb_en), .wbReg(wb_reg), .wbData(wb_data),
    .memReq(mem_req), .memAddr(mem_addr), .memData(mem_data), ._memAck(ack),
`ifdef ALU_RESULT_FORWARD_EN
    .fwdValid(fwd_valid), .fwdReg(fwd_reg), .fwdData(fwd_data),
`endif
    .compareFlag(cmp_flag), .overflowFlag(ovf_flag)
  );

  task automatic quiet();
    valid = 0; ovf = 0; cmpb = 0; flush = 0; clr = 0; ack = 0;
    result = '0; func = F_ADD; dreg = '0; saddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [FW-1:0] f, input logic [DW-1:0] r, input logic [RW-1:0] d,
                    input logic o, input logic c);
    valid = 1; func = f; result = r; dreg = d; ovf = o; cmpb = c;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if ({ready, wb_en, mem_req, cmp_flag, ovf_flag} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 10000", {ready, wb_en, mem_req, cmp_flag, ovf_flag});
    end
    n_tests++;
    if ({wb_reg, wb_data, mem_addr, mem_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", wb_reg, wb_data, mem_addr, mem_data);
    end
    ack = 1;
    tick();
    tick();
    ack = 0;
    n_tests++;
    if (mem_req !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_ack: memReq=%b ready=%b want 0 1", mem_req, ready);
    end
  endtask

  task automatic test_writeback();
    op(F_ADD, 8'h2A, 3'd3, 0, 0);
    tick();
    quiet();
    n_tests++;
    if (wb_en !== 1'b1 || wb_reg !== 3'd3 || wb_data !== 8'h2A) begin
      n_fail++; $display("FAIL wb_first: en=%b reg=%0d data=%h want 1 3 2a", wb_en, wb_reg, wb_data);
    end
    tick();
    n_tests++;
    if (wb_en !== 1'b0 || wb_reg !== 3'd3 || wb_data !== 8'h2A) begin
      n_fail++; $display("FAIL wb_drop: en=%b reg=%0d data=%h want 0 3 2a", wb_en, wb_reg, wb_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      op(F_ADD, 8'h10 + 8'(i), 3'(i + 1), 0, 0);
      tick();
      n_tests++;
      if (wb_en !== 1'b1 || wb_reg !== 3'(i + 1) || wb_data !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL b2b_%0d: en=%b reg=%0d data=%h want 1 %0d %h",
                           i, wb_en, wb_reg, wb_data, i + 1, 8'h10 + 8'(i));
      end
    end
    quiet();
    tick();
  endtask

  task automatic test_overflow();
    op(F_ADD, 8'h01, 3'd1, 1, 0);
    tick();
    n_tests++;
    if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_flag); end
    op(F_ADD, 8'h02, 3'd1, 0, 0);
    tick();
    tick();
    n_tests++;
    if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_flag); end
    op(F_ADD, 8'h03, 3'd1, 1, 0);
    clr = 1;
    tick();
    n_tests++;
    if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", ovf_flag); end
    quiet();
    clr = 1;
    tick();
    clr = 0;
    n_tests++;
    if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf_flag); end
  endtask

  task automatic test_store();
    op(F_SV, 8'h55, 3'd2, 0, 0);
    saddr = 8'h10;
    tick();
    quiet();
    op(F_ADD, 8'hEE, 3'd5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h10 || mem_data !== 8'h55 || ready !== 1'b0 || wb_en !== 1'b0) begin
        n_fail++; $display("FAIL store_hold_%0d: req=%b addr=%h data=%h ready=%b wb=%b want 1 10 55 0 0",
                           i, mem_req, mem_addr, mem_data, ready, wb_en);
      end
      tick();
    end
    quiet();
    ack = 1;
    tick();
    ack = 0;
    n_tests++;
    if (mem_req !== 1'b0 || ready !== 1'b1 || mem_addr !== 8'h10 || mem_data !== 8'h55) begin
      n_fail++; $display("FAIL store_ack: req=%b ready=%b addr=%h data=%h want 0 1 10 55",
                         mem_req, ready, mem_addr, mem_data);
    end
  endtask

  task automatic test_compare();
    op(F_LSS, 8'h00, 3'd0, 0, 1);
    tick();
    n_tests++;
    if (cmp_flag !== 1'b1) begin n_fail++; $display("FAIL cmp_lss: got %b want 1", cmp_flag); end
    op(F_ADD, 8'h00, 3'd0, 0, 0);
    tick();
    n_tests++;
    if (cmp_flag !== 1'b1) begin n_fail++; $display("FAIL cmp_hold: got %b want 1", cmp_flag); end
    op(F_EQL, 8'h00, 3'd0, 0, 0);
    tick();
    n_tests++;
    if (cmp_flag !== 1'b0) begin n_fail++; $display("FAIL cmp_eql: got %b want 0", cmp_flag); end
    op(F_NOT, 8'h00, 3'd0, 0, 1);
    tick();
    quiet();
    n_tests++;
    if (cmp_flag !== 1'b1) begin n_fail++; $display("FAIL cmp_not: got %b want 1", cmp_flag); end
    tick();
  endtask

  task automatic test_flush();
    op(F_GRT, 8'h77, 3'd6, 1, 0);
    flush = 1;
    tick();
    quiet();
    n_tests++;
    if (wb_en !== 1'b0 || cmp_flag !== 1'b1 || ovf_flag !== 1'b0) begin
      n_fail++; $display("FAIL flush_block: wb=%b cmp=%b ovf=%b want 0 1 0", wb_en, cmp_flag, ovf_flag);
    end
    op(F_SV, 8'hA5, 3'd0, 0, 0);
    saddr = 8'h3C;
    tick();
    quiet();
    flush = 1;
    tick();
    flush = 0;
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h3C || mem_data !== 8'hA5) begin
      n_fail++; $display("FAIL flush_store: req=%b addr=%h data=%h want 1 3c a5", mem_req, mem_addr, mem_data);
    end
    ack = 1;
    tick();
    ack = 0;
    n_tests++;
    if (mem_req !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_store_done: req=%b ready=%b want 0 1", mem_req, ready);
    end
  endtask

  task automatic test_reset_mid_store();
    op(F_SV, 8'h99, 3'd0, 0, 0);
    saddr = 8'h44;
    tick();
    quiet();
    n_tests++;
    if (mem_req !== 1'b1 || ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_store_pre: req=%b ready=%b want 1 0", mem_req, ready);
    end
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if (mem_req !== 1'b0 || ready !== 1'b1 || mem_addr !== 8'h00) begin
      n_fail++; $display("FAIL mid_store_reset: req=%b ready=%b addr=%h want 0 1 00", mem_req, ready, mem_addr);
    end
  endtask

  // Behavioural reference: a pending store is either outstanding or not; flags follow the op rules.
  task automatic test_random();
    bit            m_busy, m_wb, m_cmp, m_ovf;
    logic [RW-1:0] m_wreg;
    logic [DW-1:0] m_wdata, m_sdata;
    logic [AW-1:0] m_saddr;
    bit            acc;
    quiet();
    rst = 1;
    tick();
    rst = 0;
    m_busy = 0; m_wb = 0; m_cmp = 0; m_ovf = 0;
    m_wreg = '0; m_wdata = '0; m_sdata = '0; m_saddr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      valid  = ($urandom_range(0, 9) < 7);
      flush  = ($urandom_range(0, 9) == 0);
      clr    = ($urandom_range(0, 9) == 0);
      ack    = ($urandom_range(0, 9) < 3);
      ovf    = ($urandom_range(0, 5) == 0);
      cmpb   = 1'($urandom);
      func   = FW'($urandom_range(0, 9));
      result = DW'($urandom);
      dreg   = RW'($urandom);
      saddr  = AW'($urandom);
      #1;
      n_tests++;
      if (ready !== !m_busy) begin
        n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, ready, !m_busy);
      end
      acc = valid && !m_busy && !flush;
      m_wb = acc && (func != F_SV);
      if (m_wb) begin m_wreg = dreg; m_wdata = result; end
      if (m_busy && ack) m_busy = 0;
      else if (acc && func == F_SV) begin m_busy = 1; m_saddr = saddr; m_sdata = result; end
      if (acc && (func == F_NOT || func == F_LSS || func == F_EQL || func == F_GRT)) m_cmp = cmpb;
      if (acc && ovf) m_ovf = 1;
      else if (clr) m_ovf = 0;
      tick();
      n_tests++;
      if (wb_en !== m_wb || wb_reg !== m_wreg || wb_data !== m_wdata) begin
        n_fail++; $display("FAIL rnd_wb@%0d: got %b %0d %h want %b %0d %h",
                           cyc, wb_en, wb_reg, wb_data, m_wb, m_wreg, m_wdata);
      end
      n_tests++;
      if (mem_req !== m_busy || mem_addr !== m_saddr || mem_data !== m_sdata) begin
        n_fail++; $display("FAIL rnd_mem@%0d: got %b %h %h want %b %h %h",
                           cyc, mem_req, mem_addr, mem_data, m_busy, m_saddr, m_sdata);
      end
      n_tests++;
      if (cmp_flag !== m_cmp || ovf_flag !== m_ovf) begin
        n_fail++; $display("FAIL rnd_flags@%0d: got cmp=%b ovf=%b want %b %b", cyc, cmp_flag, ovf_flag, m_cmp, m_ovf);
      end
    end
    quiet();
  endtask

  initial begin
    rst = 1;
    quiet();
    tick();
    test_reset();
    test_writeback();
    test_back_to_back();
    test_overflow();
    test_store();
    test_compare();
    test_flush();
    test_reset_mid_store();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
